// File: rtl/instr_fetch_mt_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_mt_pkg
//
// Shared definitions for the multithreaded instruction-fetch unit:
//   - default instruction address / instruction word widths
//   - FSM state encoding (kept as plain localparam constants so that older
//     tools and hand-written netlists can match the encoding bit-for-bit)
//   - a helper that turns a table depth into a safe index width
//
// No ports (package).
// ---------------------------------------------------------------------------
package instr_fetch_mt_pkg;

    localparam int IF_IADDR_LEN = 10;
    localparam int IF_INSTR_LEN = 16;

    // Fetch FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    // Index width for a table of n entries; never returns 0 so that a
    // single-entry table still gets a legal one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_fetch_mt_rr_thread_sel.sv
// ---------------------------------------------------------------------------
// instr_fetch_mt_rr_thread_sel
//
// Round-robin thread picker with a registered "current thread" number.
// The pick is the lowest-indexed ready thread strictly after the current
// one, wrapping around; the current thread itself is only chosen when no
// other thread is ready.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset (current thread -> 0)
//   thread_rdy_i   per-thread ready flags
//   advance_i      load the pick into the current-thread register
//   any_rdy_o      at least one thread is ready (combinational)
//   thread_num_o   registered current thread number
// ---------------------------------------------------------------------------
module instr_fetch_mt_rr_thread_sel
    import instr_fetch_mt_pkg::*;
#(
    parameter int N_THREADS = 12,
    localparam int TW = idx_width(N_THREADS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_THREADS-1:0] thread_rdy_i,
    input  logic                 advance_i,
    output logic                 any_rdy_o,
    output logic [TW-1:0]        thread_num_o
);

    logic [TW-1:0] threadNum_q;
    logic [TW-1:0] threadNum_d;
    logic [TW-1:0] pick;
    int            idx;

    // Walk the offsets from farthest to nearest so that the nearest ready
    // thread after the current one overwrites everything else. Offset
    // N_THREADS lands back on the current thread, giving it lowest priority.
    always_comb begin
        pick      = threadNum_q;
        any_rdy_o = 1'b0;
        idx       = 0;
        for (int off = N_THREADS; off >= 1; off--) begin
            idx = int'(threadNum_q) + off;
            if (idx >= N_THREADS) begin
                idx = idx - N_THREADS;
            end
            if (thread_rdy_i[idx[TW-1:0]]) begin
                pick      = idx[TW-1:0];
                any_rdy_o = 1'b1;
            end
        end
    end

    // Only move when asked to and when there is somewhere to move to;
    // otherwise the current thread number is held.
    always_comb begin
        threadNum_d = threadNum_q;
        if (advance_i && any_rdy_o) begin
            threadNum_d = pick;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            threadNum_q <= '0;
        end else begin
            threadNum_q <= threadNum_d;
        end
    end

    assign thread_num_o = threadNum_q;

endmodule

// File: rtl/instr_fetch_mt.sv
// ---------------------------------------------------------------------------
// instr_fetch_mt
//
// Multithreaded instruction-fetch unit for the md5crypt soft CPU.
// Keeps a per-thread resume IP, a per-thread single-level return register
// and a host-loadable entry-point table, picks the next ready thread
// round-robin, and streams instructions out of a runtime-writable program
// block RAM through a LOAD -> FETCH -> RUN sequence.
//
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   entry_pt_sel   entry point used by threads that (re)initialise
//   ep_wr_en/idx/addr          entry-point table write port
//   prog_wr_en/addr/data       program memory write port
//   thread_rdy     per-thread ready flags
//   thread_num     thread currently executing
//   instruction    fetched instruction word
//   instr_valid    instruction is valid (RUN state)
//   INSTR_WAIT     stall: hold IP and instruction register
//   EXECUTED       current instruction retired (advances effective IP)
//   NEXT_THREAD    save current thread and switch
//   JUMP/CALL/RET  control-flow qualifiers of NEXT_THREAD
//   jump_addr      jump target
//   err            sticky protocol error flag
// ---------------------------------------------------------------------------
module instr_fetch_mt
    import instr_fetch_mt_pkg::*;
#(
    parameter int N_THREADS    = 12,
    parameter int IADDR_LEN    = IF_IADDR_LEN,
    parameter int INSTR_LEN    = IF_INSTR_LEN,
    parameter int N_ENTRY_PTS  = 4,
    parameter int EP_DEFAULT_1 = 150,
    localparam int TW = idx_width(N_THREADS),
    localparam int EW = idx_width(N_ENTRY_PTS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [EW-1:0]        entry_pt_sel,
    input  logic                 ep_wr_en,
    input  logic [EW-1:0]        ep_wr_idx,
    input  logic [IADDR_LEN-1:0] ep_wr_addr,
    input  logic                 prog_wr_en,
    input  logic [IADDR_LEN-1:0] prog_wr_addr,
    input  logic [INSTR_LEN-1:0] prog_wr_data,
    input  logic [N_THREADS-1:0] thread_rdy,
    output logic [TW-1:0]        thread_num,
    output logic [INSTR_LEN-1:0] instruction,
    output logic                 instr_valid,
    input  logic                 INSTR_WAIT,
    input  logic                 EXECUTED,
    input  logic                 NEXT_THREAD,
    input  logic                 JUMP,
    input  logic                 CALL,
    input  logic                 RET,
    input  logic [IADDR_LEN-1:0] jump_addr,
    output logic                 err
);

    localparam logic [IADDR_LEN-1:0] ADDR_ONE = {{(IADDR_LEN-1){1'b0}}, 1'b1};
    localparam int                   MEM_DEPTH = 2 ** IADDR_LEN;

    // FSM and per-thread control state
    logic [1:0]           state_q, state_d;
    logic [IADDR_LEN-1:0] fetchAddr_q, fetchAddr_d;
    logic [IADDR_LEN-1:0] ipEff_q, ipEff_d;
    logic                 err_q, err_d;
    logic [N_THREADS-1:0] initFlag_q, initFlag_d;
    logic [N_THREADS-1:0] retValid_q, retValid_d;
    logic [EW-1:0]        prevSel_q;
    logic [IADDR_LEN-1:0] epTable_q [N_ENTRY_PTS];

    // Storage that is deliberately not reset
    logic [IADDR_LEN-1:0] ipTable_q [N_THREADS];
    logic [IADDR_LEN-1:0] retAddr_q [N_THREADS];
    logic [INSTR_LEN-1:0] progMem_q [MEM_DEPTH];
    logic [INSTR_LEN-1:0] rdData_q;

    logic                 anyRdy;
    logic                 advance;
    logic                 inRun;
    logic                 switchNow;
    logic                 rdEn;
    logic                 errSet;
    logic [IADDR_LEN-1:0] loadIp;
    logic [IADDR_LEN-1:0] saveIp;

    assign inRun     = (state_q == ST_RUN);
    assign switchNow = inRun && NEXT_THREAD;
    assign advance   = (state_q == ST_IDLE) || switchNow;

    instr_fetch_mt_rr_thread_sel #(
        .N_THREADS (N_THREADS)
    ) u_sel (
        .clk_i        (CLK),
        .rst_i        (RST),
        .thread_rdy_i (thread_rdy),
        .advance_i    (advance),
        .any_rdy_o    (anyRdy),
        .thread_num_o (thread_num)
    );

    // A thread whose init flag is set starts from the selected entry point
    // instead of its saved IP. The entry table is read from its registers,
    // so a same-cycle write to the same index is not yet visible here.
    assign loadIp = initFlag_q[thread_num] ? epTable_q[entry_pt_sel]
                                           : ipTable_q[thread_num];

    // Resume IP saved on a thread switch, highest priority first.
    always_comb begin
        if (JUMP) begin
            saveIp = jump_addr;
        end else if (RET) begin
            saveIp = retAddr_q[thread_num];
        end else if (EXECUTED) begin
            saveIp = ipEff_q + ADDR_ONE;
        end else begin
            saveIp = ipEff_q;
        end
    end

    // Protocol violations. They only raise the flag; the functional update
    // still happens exactly as it would without the violation.
    assign errSet = (CALL && retValid_q[thread_num])
                 || (RET && !retValid_q[thread_num])
                 || (JUMP && RET)
                 || (CALL && !JUMP)
                 || (NEXT_THREAD && INSTR_WAIT)
                 || ((EXECUTED || NEXT_THREAD) && !inRun);

    // Next-state logic for the fetch FSM and the per-thread flags.
    // fetchAddr is the address of the next BRAM read, i.e. one ahead of the
    // instruction currently presented; ipEff only moves on EXECUTED.
    always_comb begin
        state_d     = state_q;
        fetchAddr_d = fetchAddr_q;
        ipEff_d     = ipEff_q;
        initFlag_d  = initFlag_q;
        retValid_d  = retValid_q;
        rdEn        = 1'b0;
        err_d       = err_q | errSet;

        case (state_q)
            ST_IDLE: begin
                if (anyRdy) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                fetchAddr_d            = loadIp;
                ipEff_d                = loadIp;
                initFlag_d[thread_num] = 1'b0;
                state_d                = ST_FETCH;
            end
            ST_FETCH: begin
                rdEn        = 1'b1;
                fetchAddr_d = fetchAddr_q + ADDR_ONE;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (NEXT_THREAD) begin
                    state_d = anyRdy ? ST_LOAD : ST_IDLE;
                    if (CALL && JUMP) begin
                        retValid_d[thread_num] = 1'b1;
                    end else if (RET) begin
                        retValid_d[thread_num] = 1'b0;
                    end
                end else begin
                    if (!INSTR_WAIT) begin
                        rdEn        = 1'b1;
                        fetchAddr_d = fetchAddr_q + ADDR_ONE;
                    end
                    if (EXECUTED) begin
                        ipEff_d = ipEff_q + ADDR_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new entry point forces every thread to restart from it at its
        // next LOAD; the running thread is left alone until it switches.
        if (entry_pt_sel != prevSel_q) begin
            initFlag_d = '1;
        end
    end

    // Resettable control state and the entry-point table.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            fetchAddr_q <= '0;
            ipEff_q     <= '0;
            err_q       <= 1'b0;
            initFlag_q  <= '1;
            retValid_q  <= '0;
            prevSel_q   <= entry_pt_sel;
            for (int i = 0; i < N_ENTRY_PTS; i++) begin
                if (i == 1) begin
                    epTable_q[i] <= IADDR_LEN'(EP_DEFAULT_1);
                end else begin
                    epTable_q[i] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            fetchAddr_q <= fetchAddr_d;
            ipEff_q     <= ipEff_d;
            err_q       <= err_d;
            initFlag_q  <= initFlag_d;
            retValid_q  <= retValid_d;
            prevSel_q   <= entry_pt_sel;
            if (ep_wr_en) begin
                epTable_q[ep_wr_idx] <= ep_wr_addr;
            end
        end
    end

    // Per-thread resume IP and return address; contents survive reset.
    always_ff @(posedge CLK) begin
        if (!RST && switchNow) begin
            ipTable_q[thread_num] <= saveIp;
            if (CALL && JUMP) begin
                retAddr_q[thread_num] <= ipEff_q + ADDR_ONE;
            end
        end
    end

    // Simple dual-port program RAM. Write and read share one process so the
    // read returns the pre-write contents on an address collision.
    always_ff @(posedge CLK) begin
        if (prog_wr_en) begin
            progMem_q[prog_wr_addr] <= prog_wr_data;
        end
        if (rdEn) begin
            rdData_q <= progMem_q[fetchAddr_q];
        end
    end

    assign instruction = rdData_q;
    assign instr_valid = inRun;
    assign err         = err_q;

endmodule

// File: tb/tb_instr_fetch_mt.sv
module tb_instr_fetch_mt;

    localparam int NT = 12;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int NE = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [1:0]    entry_pt_sel;
    logic          ep_wr_en;
    logic [1:0]    ep_wr_idx;
    logic [AW-1:0] ep_wr_addr;
    logic          prog_wr_en;
    logic [AW-1:0] prog_wr_addr;
    logic [DW-1:0] prog_wr_data;
    logic [NT-1:0] thread_rdy;
    logic [3:0]    thread_num;
    logic [DW-1:0] instruction;
    logic          instr_valid;
    logic          INSTR_WAIT;
    logic          EXECUTED;
    logic          NEXT_THREAD;
    logic          JUMP;
    logic          CALL;
    logic          RET;
    logic [AW-1:0] jump_addr;
    logic          err;

    int vecCount  = 0;
    int missCount = 0;

    always #5 CLK = ~CLK;

    instr_fetch_mt #(
        .N_THREADS    (NT),
        .IADDR_LEN    (AW),
        .INSTR_LEN    (DW),
        .N_ENTRY_PTS  (NE),
        .EP_DEFAULT_1 (150)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .entry_pt_sel (entry_pt_sel),
        .ep_wr_en     (ep_wr_en),
        .ep_wr_idx    (ep_wr_idx),
        .ep_wr_addr   (ep_wr_addr),
        .prog_wr_en   (prog_wr_en),
        .prog_wr_addr (prog_wr_addr),
        .prog_wr_data (prog_wr_data),
        .thread_rdy   (thread_rdy),
        .thread_num   (thread_num),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .INSTR_WAIT   (INSTR_WAIT),
        .EXECUTED     (EXECUTED),
        .NEXT_THREAD  (NEXT_THREAD),
        .JUMP         (JUMP),
        .CALL         (CALL),
        .RET          (RET),
        .jump_addr    (jump_addr),
        .err          (err)
    );

    // Background program image: every word encodes its own address.
    function automatic logic [DW-1:0] pat(input int a);
        logic [31:0] av;
        av = a;
        return 16'hC000 | {6'd0, av[9:0]};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ctrl();
        INSTR_WAIT  = 1'b0;
        EXECUTED    = 1'b0;
        NEXT_THREAD = 1'b0;
        JUMP        = 1'b0;
        CALL        = 1'b0;
        RET         = 1'b0;
        ep_wr_en    = 1'b0;
        prog_wr_en  = 1'b0;
    endtask

    task automatic load_program();
        for (int a = 0; a < 1024; a++) begin
            prog_wr_en   = 1'b1;
            prog_wr_addr = AW'(a);
            prog_wr_data = (a == 150) ? 16'hABCD : pat(a);
            step();
        end
        prog_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        entry_pt_sel = 2'd1;
        thread_rdy = '0;
        step();
        step();
        RST = 1'b0;
        vecCount++;
        if (thread_num !== 4'd0) begin
            missCount++;
            $display("[TB] FAIL reset_thread_num got %0d want 0", thread_num);
        end
        vecCount++;
        if (instr_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_valid got %b want 0", instr_valid);
        end
        vecCount++;
        if (err !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_err got %b want 0", err);
        end
    endtask

    task automatic test_first_fetch();
        step();
        step();
        vecCount++;
        if (instr_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL idle_no_ready got %b want 0", instr_valid);
        end
        thread_rdy = 12'h001;
        step();
        vecCount++;
        if (thread_num !== 4'd0 || instr_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL first_load got thr=%0d v=%b want thr=0 v=0", thread_num, instr_valid);
        end
        step();
        vecCount++;
        if (instr_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL first_fetch_valid got %b want 0", instr_valid);
        end
        step();
        vecCount++;
        if (instr_valid !== 1'b1 || instruction !== 16'hABCD) begin
            missCount++;
            $display("[TB] FAIL first_instr got v=%b %h want v=1 abcd", instr_valid, instruction);
        end
        step();
        vecCount++;
        if (instruction !== 16'hC097) begin
            missCount++;
            $display("[TB] FAIL second_instr got %h want c097", instruction);
        end
    endtask

    task automatic test_resume_executed();
        entry_pt_sel = 2'd0;
        step();
        thread_rdy  = 12'h008;
        NEXT_THREAD = 1'b1;
        step();
        NEXT_THREAD = 1'b0;
        vecCount++;
        if (thread_num !== 4'd3 || instr_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL switch_to_3 got thr=%0d v=%b want thr=3 v=0", thread_num, instr_valid);
        end
        step();
        step();
        vecCount++;
        if (instr_valid !== 1'b1 || instruction !== 16'hC000) begin
            missCount++;
            $display("[TB] FAIL thr3_start got v=%b %h want v=1 c000", instr_valid, instruction);
        end
        EXECUTED = 1'b1;
        repeat (20) step();
        thread_rdy  = 12'hFFF;
        NEXT_THREAD = 1'b1;
        step();
        EXECUTED    = 1'b0;
        NEXT_THREAD = 1'b0;
        vecCount++;
        if (thread_num !== 4'd4) begin
            missCount++;
            $display("[TB] FAIL rr_pick_4 got %0d want 4", thread_num);
        end
        step();
        step();
        vecCount++;
        if (instruction !== 16'hC000) begin
            missCount++;
            $display("[TB] FAIL thr4_start got %h want c000", instruction);
        end
        thread_rdy  = 12'h008;
        NEXT_THREAD = 1'b1;
        step();
        NEXT_THREAD = 1'b0;
        step();
        step();
        vecCount++;
        if (thread_num !== 4'd3 || instruction !== 16'hC015) begin
            missCount++;
            $display("[TB] FAIL thr3_resume got thr=%0d %h want thr=3 c015", thread_num, instruction);
        end
    endtask

    task automatic test_call_ret();
        EXECUTED = 1'b1;
        repeat (19) step();
        EXECUTED    = 1'b0;
        CALL        = 1'b1;
        JUMP        = 1'b1;
        NEXT_THREAD = 1'b1;
        jump_addr   = 10'd300;
        step();
        clear_ctrl();
        step();
        step();
        vecCount++;
        if (thread_num !== 4'd3 || instruction !== 16'hC12C) begin
            missCount++;
            $display("[TB] FAIL call_target got thr=%0d %h want thr=3 c12c", thread_num, instruction);
        end
        RET         = 1'b1;
        NEXT_THREAD = 1'b1;
        step();
        clear_ctrl();
        step();
        step();
        vecCount++;
        if (instruction !== 16'hC029) begin
            missCount++;
            $display("[TB] FAIL ret_target got %h want c029", instruction);
        end
        vecCount++;
        if (err !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL call_ret_err got %b want 0", err);
        end
    endtask

    task automatic test_err_sticky();
        RET         = 1'b1;
        NEXT_THREAD = 1'b1;
        step();
        clear_ctrl();
        vecCount++;
        if (err !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL ret_unbalanced_err got %b want 1", err);
        end
        step();
        step();
        vecCount++;
        if (instruction !== 16'hC029) begin
            missCount++;
            $display("[TB] FAIL ret_err_ip got %h want c029", instruction);
        end
        repeat (5) step();
        vecCount++;
        if (err !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL err_sticky got %b want 1", err);
        end
        RST        = 1'b1;
        thread_rdy = '0;
        step();
        RST = 1'b0;
        vecCount++;
        if (err !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL err_cleared got %b want 0", err);
        end
    endtask

    task automatic test_entry_switch();
        thread_rdy = 12'h002;
        step();
        vecCount++;
        if (thread_num !== 4'd1) begin
            missCount++;
            $display("[TB] FAIL pick_1 got %0d want 1", thread_num);
        end
        ep_wr_en   = 1'b1;
        ep_wr_idx  = 2'd0;
        ep_wr_addr = 10'd700;
        step();
        ep_wr_en = 1'b0;
        step();
        vecCount++;
        if (instruction !== 16'hC000) begin
            missCount++;
            $display("[TB] FAIL ep_write_during_load got %h want c000", instruction);
        end
        ep_wr_en   = 1'b1;
        ep_wr_idx  = 2'd2;
        ep_wr_addr = 10'd500;
        step();
        ep_wr_en     = 1'b0;
        entry_pt_sel = 2'd2;
        step();
        vecCount++;
        if (thread_num !== 4'd1 || instr_valid !== 1'b1 || instruction !== 16'hC002) begin
            missCount++;
            $display("[TB] FAIL sel_change_run got thr=%0d v=%b %h want thr=1 v=1 c002", thread_num, instr_valid, instruction);
        end
        step();
        vecCount++;
        if (instruction !== 16'hC003) begin
            missCount++;
            $display("[TB] FAIL sel_change_cont got %h want c003", instruction);
        end
        thread_rdy  = 12'h004;
        NEXT_THREAD = 1'b1;
        step();
        NEXT_THREAD = 1'b0;
        step();
        step();
        vecCount++;
        if (thread_num !== 4'd2 || instruction !== 16'hC1F4) begin
            missCount++;
            $display("[TB] FAIL thr2_ep2 got thr=%0d %h want thr=2 c1f4", thread_num, instruction);
        end
        thread_rdy  = 12'h002;
        NEXT_THREAD = 1'b1;
        step();
        NEXT_THREAD = 1'b0;
        step();
        step();
        vecCount++;
        if (thread_num !== 4'd1 || instruction !== 16'hC1F4) begin
            missCount++;
            $display("[TB] FAIL thr1_ep2 got thr=%0d %h want thr=1 c1f4", thread_num, instruction);
        end
    endtask

    task automatic test_stall();
        step();
        vecCount++;
        if (instruction !== 16'hC1F5) begin
            missCount++;
            $display("[TB] FAIL pre_stall got %h want c1f5", instruction);
        end
        INSTR_WAIT = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                prog_wr_en   = 1'b1;
                prog_wr_addr = 10'd502;
                prog_wr_data = 16'h1234;
            end
            step();
            prog_wr_en = 1'b0;
            vecCount++;
            if (instruction !== 16'hC1F5 || instr_valid !== 1'b1) begin
                missCount++;
                $display("[TB] FAIL stall_hold%0d got v=%b %h want v=1 c1f5", c, instr_valid, instruction);
            end
        end
        INSTR_WAIT = 1'b0;
        step();
        vecCount++;
        if (instruction !== 16'h1234) begin
            missCount++;
            $display("[TB] FAIL stall_new_data got %h want 1234", instruction);
        end
        step();
        vecCount++;
        if (instruction !== 16'hC1F7) begin
            missCount++;
            $display("[TB] FAIL post_stall got %h want c1f7", instruction);
        end
        prog_wr_en   = 1'b1;
        prog_wr_addr = 10'd504;
        prog_wr_data = 16'h5555;
        step();
        prog_wr_en = 1'b0;
        vecCount++;
        if (instruction !== 16'hC1F8) begin
            missCount++;
            $display("[TB] FAIL read_first got %h want c1f8", instruction);
        end
        JUMP        = 1'b1;
        NEXT_THREAD = 1'b1;
        jump_addr   = 10'd504;
        step();
        clear_ctrl();
        step();
        step();
        vecCount++;
        if (instruction !== 16'h5555) begin
            missCount++;
            $display("[TB] FAIL refetch_new got %h want 5555", instruction);
        end
        JUMP        = 1'b1;
        NEXT_THREAD = 1'b1;
        jump_addr   = 10'd1023;
        step();
        clear_ctrl();
        step();
        step();
        vecCount++;
        if (instruction !== 16'hC3FF) begin
            missCount++;
            $display("[TB] FAIL jump_top got %h want c3ff", instruction);
        end
        step();
        vecCount++;
        if (instruction !== 16'hC000) begin
            missCount++;
            $display("[TB] FAIL addr_wrap got %h want c000", instruction);
        end
        vecCount++;
        if (err !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL stall_err got %b want 0", err);
        end
    endtask

    task automatic test_err_stall_switch();
        INSTR_WAIT  = 1'b1;
        NEXT_THREAD = 1'b1;
        step();
        clear_ctrl();
        vecCount++;
        if (err !== 1'b1 || instr_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL switch_in_stall got err=%b v=%b want err=1 v=0", err, instr_valid);
        end
    endtask

    initial begin
        RST          = 1'b1;
        entry_pt_sel = 2'd1;
        ep_wr_idx    = '0;
        ep_wr_addr   = '0;
        prog_wr_addr = '0;
        prog_wr_data = '0;
        thread_rdy   = '0;
        jump_addr    = '0;
        clear_ctrl();
        step();
        step();
        RST = 1'b0;
        load_program();
        test_reset();
        test_first_fetch();
        test_resume_executed();
        test_call_ret();
        test_err_sticky();
        test_entry_switch();
        test_stall();
        test_err_stall_switch();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/instr_fetch_mt.md
Name: instr_fetch_mt

Overview:
- Parametrised multithreaded instruction-fetch unit for the md5crypt soft CPU; successor to the fixed 3-core fetch block.
- Holds a per-thread instruction-pointer table and picks the next ready thread round-robin.
- Fetches from a runtime-writable program BRAM through a 2-stage pipeline.
- New features: a host-loadable entry-point table and a per-thread single-level CALL/RET return register.

Parameters:
N_THREADS, 12, number of hardware threads (2..32)
IADDR_LEN, 10, instruction address width
INSTR_LEN, 16, instruction word width
N_ENTRY_PTS, 4, entry-point table depth (power of 2)
EP_DEFAULT_1, 150, reset value of entry point 1; all others reset to 0

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
entry_pt_sel  in  log2(N_ENTRY_PTS)  selects the program entry point for initialising threads
ep_wr_en  in  1  write entry-point table
ep_wr_idx  in  log2(N_ENTRY_PTS)  entry-point index to write
ep_wr_addr  in  IADDR_LEN  entry-point value to write
prog_wr_en  in  1  program memory write enable
prog_wr_addr  in  IADDR_LEN  program write address
prog_wr_data  in  INSTR_LEN  program write data
thread_rdy  in  N_THREADS  per-thread ready flags
thread_num  out  log2(N_THREADS)  thread currently executing
instruction  out  INSTR_LEN  fetched instruction
instr_valid  out  1  instruction output valid
INSTR_WAIT  in  1  hold the pipeline (stall)
EXECUTED  in  1  advance effective IP by one
NEXT_THREAD  in  1  save the current thread and switch
JUMP  in  1  with NEXT_THREAD: save jump_addr as the resume IP
CALL  in  1  with JUMP: store the return address
RET  in  1  with NEXT_THREAD: resume at the stored return address
jump_addr  in  IADDR_LEN  jump target
err  out  1  sticky error flag

Behaviour:
- RST: thread_num=0, instr_valid=0, err=0, FSM=IDLE, all init flags=1, all ret_valid=0, entry table = {0, EP_DEFAULT_1, 0, ...}. IP table and program memory are not reset.
- FSM states:
  - IDLE: if any thread_rdy, pick a thread -> LOAD.
  - LOAD: read the IP table, or the entry table if the thread's init flag is set; clear init -> FETCH.
  - FETCH: BRAM read of IP_curr -> RUN.
  - RUN: instr_valid=1.
- Thread pick: round-robin, lowest ready index strictly after the current thread, wrapping; the current thread is eligible only last. If no thread is ready, stay in IDLE with instr_valid=0.
- Switch latency: NEXT_THREAD at cycle T -> thread_num updates at T+1 (LOAD) -> new instruction valid at T+3. instr_valid=0 during T+1..T+2.
- RUN, no stall: IP_curr increments each cycle; one instruction per cycle.
- INSTR_WAIT=1 freezes IP_curr and the instruction register; instr_valid stays 1.
- EXECUTED increments IP_effective independently of IP_curr.
- IP save on NEXT_THREAD, priority order: JUMP -> jump_addr; RET -> ret_addr; EXECUTED -> IP_effective+1; otherwise IP_effective.
- CALL (requires JUMP): ret_addr[thr] <= IP_effective+1, ret_valid <= 1.
- RET: ret_valid <= 0.
- err is set (sticky until RST) on any of:
  - CALL while ret_valid=1;
  - RET while ret_valid=0;
  - JUMP and RET together;
  - CALL without JUMP;
  - NEXT_THREAD with INSTR_WAIT;
  - EXECUTED/NEXT_THREAD while not in RUN.
  In every case the state update still follows the priority order above.
- A change of entry_pt_sel sets all init flags; the running thread continues until its next NEXT_THREAD.
- Entry-table write: takes effect the following cycle. A write and a LOAD read of the same index in the same cycle return the old value.
- Program memory is read-first: a write and a fetch of the same address in the same cycle return the old data; the new data is visible on the next fetch.
- Address arithmetic wraps modulo 2^IADDR_LEN; no error is raised on wrap.
- thread_rdy deasserting for the running thread has no effect; only NEXT_THREAD switches.

Decomposition:
- Shared package/header: IADDR_LEN, INSTR_LEN, MSB macro, FSM state encoding.
- Sub-module rr_thread_sel: combinational round-robin pick plus registered thread_num. Program BRAM stays inline as SDP block RAM.

Test Plan:
1. Reset, thread_rdy=0x001, entry_pt_sel=1, program[150]=0xABCD -> thread 0, instr_valid at cycle 3, instruction=0xABCD, then program[151] the next cycle.
2. thread_rdy=0xFFF, thread 3 running, NEXT_THREAD with EXECUTED, IP_eff=20 -> thread 4 selected; when thread 3 is rescheduled it resumes at 21.
3. CALL+JUMP+NEXT_THREAD, jump_addr=300, IP_eff=40 -> thread resumes at 300; later RET+NEXT_THREAD -> resumes at 41; err=0.
4. RET with ret_valid=0 -> err=1 and stays 1 until RST.
5. Write ep[2]=500, set entry_pt_sel=2 -> every thread's next scheduling starts at 500; the running thread is unaffected until it switches.
6. INSTR_WAIT held 3 cycles mid-RUN -> instruction constant, IP_curr frozen; resumes without skipping an address. Program write to IP_curr+1 during the stall -> new data fetched.
